// File: rtl/pipe_sub_pkg.sv
// Shared constants and mode encoding for the pipelined subtractor.
package pipe_sub_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;
   localparam int unsigned DEFAULT_CHUNK = 8;

   typedef enum logic {
      SAT_WRAP  = 1'b0,
      SAT_CLAMP = 1'b1
   } sat_mode_e;

endpackage

// File: rtl/sub_slice.sv
// Combinational W-bit subtract-with-borrow slice: diff = a - b - bin.
module sub_slice #(
   parameter int unsigned W = 8
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         bin,
   output logic [W-1:0] diff,
   output logic         bout
);

   logic [W:0] full;

   // The extra top bit of the widened difference is the borrow-out.
   assign full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
   assign diff = full[W-1:0];
   assign bout = full[W];

endmodule

// File: rtl/pipe_sub.sv
// Pipelined subtractor: one CHUNK-bit borrow slice per stage, global stall on the output
// handshake, optional unsigned clamp-to-zero on underflow.
module pipe_sub
   import pipe_sub_pkg::*;
#(
   parameter int unsigned WIDTH = DEFAULT_WIDTH,
   parameter int unsigned CHUNK = DEFAULT_CHUNK
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             bin,
   input  logic             sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] diff,
   output logic             bout,
   output logic             ovf,
   output logic             zero
);

   localparam int unsigned STAGES = WIDTH / CHUNK;

   if (WIDTH % CHUNK != 0) begin : g_width_check
      $error("pipe_sub: WIDTH must be an integer multiple of CHUNK");
   end

   logic en;

   assign en       = ~out_valid | out_ready;
   assign in_ready = en;

   // Inputs seen by stage k: index 0 comes from the ports, index k from stage k-1 registers.
   logic             st_v   [STAGES];
   logic [WIDTH-1:0] st_a   [STAGES];
   logic [WIDTH-1:0] st_b   [STAGES];
   logic [WIDTH-1:0] st_d   [STAGES];
   logic             st_br  [STAGES];
   logic             st_sat [STAGES];
   logic             st_nz  [STAGES];

   assign st_v[0]   = in_valid;
   assign st_a[0]   = a;
   assign st_b[0]   = b;
   assign st_d[0]   = '0;
   assign st_br[0]  = bin;
   assign st_sat[0] = sat;
   assign st_nz[0]  = 1'b0;

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [CHUNK-1:0] c_diff;
      logic             c_bout;
      logic [WIDTH-1:0] d_next;
      logic             nz_next;

      sub_slice #(
         .W(CHUNK)
      ) u_slice (
         .a   (st_a[k][k*CHUNK +: CHUNK]),
         .b   (st_b[k][k*CHUNK +: CHUNK]),
         .bin (st_br[k]),
         .diff(c_diff),
         .bout(c_bout)
      );

      always_comb begin
         d_next = st_d[k];
         d_next[k*CHUNK +: CHUNK] = c_diff;
      end

      // Running "some chunk so far is nonzero" flag avoids a full-width compare at the end.
      assign nz_next = st_nz[k] | (|c_diff);

      if (k < STAGES - 1) begin : g_mid
         logic             v_q;
         logic [WIDTH-1:0] a_q;
         logic [WIDTH-1:0] b_q;
         logic [WIDTH-1:0] d_q;
         logic             br_q;
         logic             sat_q;
         logic             nz_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               v_q   <= 1'b0;
               a_q   <= '0;
               b_q   <= '0;
               d_q   <= '0;
               br_q  <= 1'b0;
               sat_q <= 1'b0;
               nz_q  <= 1'b0;
            end else if (en) begin
               v_q   <= st_v[k];
               a_q   <= st_a[k];
               b_q   <= st_b[k];
               d_q   <= d_next;
               br_q  <= c_bout;
               sat_q <= st_sat[k];
               nz_q  <= nz_next;
            end
         end

         assign st_v[k+1]   = v_q;
         assign st_a[k+1]   = a_q;
         assign st_b[k+1]   = b_q;
         assign st_d[k+1]   = d_q;
         assign st_br[k+1]  = br_q;
         assign st_sat[k+1] = sat_q;
         assign st_nz[k+1]  = nz_q;
      end else begin : g_last
         logic             clamp;
         logic [WIDTH-1:0] diff_next;
         logic             ovf_next;
         logic             zero_next;

         always_comb begin
            clamp     = (st_sat[k] == logic'(SAT_CLAMP)) & c_bout;
            diff_next = clamp ? '0 : d_next;
            ovf_next  = (st_a[k][WIDTH-1] ^ st_b[k][WIDTH-1]) &
                        (st_a[k][WIDTH-1] ^ d_next[WIDTH-1]);
            zero_next = clamp | ~nz_next;
         end

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               out_valid <= 1'b0;
               diff      <= '0;
               bout      <= 1'b0;
               ovf       <= 1'b0;
               zero      <= 1'b0;
            end else if (en) begin
               out_valid <= st_v[k];
               diff      <= diff_next;
               bout      <= c_bout;
               ovf       <= ovf_next;
               zero      <= zero_next;
            end
         end
      end
   end

endmodule

// File: tb/tb_pipe_sub.sv
// Self-checking bench for pipe_sub (WIDTH 32, CHUNK 8): directed vectors, stall pattern,
// asynchronous reset and a randomized regression against a queue-based reference model.
module tb_pipe_sub;

   logic        clk = 1'b0;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] a;
   logic [31:0] b;
   logic        bin;
   logic        sat;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] diff;
   logic        bout;
   logic        ovf;
   logic        zero;

   always #5 clk = ~clk;

   pipe_sub #(
      .WIDTH(32),
      .CHUNK(8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .in_valid (in_valid),
      .in_ready (in_ready),
      .a        (a),
      .b        (b),
      .bin      (bin),
      .sat      (sat),
      .out_valid(out_valid),
      .out_ready(out_ready),
      .diff     (diff),
      .bout     (bout),
      .ovf      (ovf),
      .zero     (zero)
   );

   typedef struct packed {
      logic [31:0] diff;
      logic        bout;
      logic        ovf;
      logic        zero;
   } res_t;

   res_t        exp_q[$];
   int          n_checks  = 0;
   int          n_errors  = 0;
   int          n_retired = 0;
   logic        s_acc;
   logic        s_ov;
   logic [31:0] s_diff;
   logic        s_bout;
   logic        s_ovf;
   logic        s_zero;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Reference: unsigned a - b - bin with wide arithmetic, then the clamp and flag rules.
   function automatic res_t model(input logic [31:0] ma, input logic [31:0] mb,
                                  input logic mbin, input logic msat);
      res_t        r;
      logic [63:0] wa;
      logic [63:0] wb;
      logic [31:0] wrapped;
      wa      = {32'd0, ma};
      wb      = {32'd0, mb} + {63'd0, mbin};
      wrapped = 32'(wa - wb);
      r.bout  = (wa < wb);
      r.ovf   = (ma[31] ^ mb[31]) & (ma[31] ^ wrapped[31]);
      r.diff  = (msat && r.bout) ? 32'd0 : wrapped;
      r.zero  = (r.diff == 32'd0);
      return r;
   endfunction

   function automatic logic [31:0] rand_op();
      logic [31:0] s;
      s = 32'($urandom_range(0, 3));
      case ($urandom_range(0, 3))
         0:       return 32'($urandom());
         1:       return s;
         2:       return 32'h8000_0000 ^ s;
         default: return 32'hFFFF_FFFF - s;
      endcase
   endfunction

   // One clock: drive at the falling edge, settle, then check and update the model.
   task automatic cycle(input logic iv, input logic [31:0] ia, input logic [31:0] ib,
                        input logic ibin, input logic isat, input logic ordy);
      res_t head;
      @(negedge clk);
      in_valid  = iv;
      a         = ia;
      b         = ib;
      bin       = ibin;
      sat       = isat;
      out_ready = ordy;
      #1;
      s_ov   = out_valid;
      s_diff = diff;
      s_bout = bout;
      s_ovf  = ovf;
      s_zero = zero;
      s_acc  = iv && in_ready;
      check_val("in_ready", in_ready, !out_valid || ordy);
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            check_val("spurious_out_valid", 1, 0);
         end else begin
            head = exp_q[0];
            check_val("diff", diff, head.diff);
            check_val("bout", bout, head.bout);
            check_val("ovf", ovf, head.ovf);
            check_val("zero", zero, head.zero);
         end
      end
      if (out_valid && ordy && exp_q.size() > 0) begin
         void'(exp_q.pop_front());
         n_retired++;
      end
      if (s_acc) exp_q.push_back(model(ia, ib, ibin, isat));
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (exp_q.size() > 0 && n < 40) begin
         cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
         n++;
      end
      check_val("drain_empty", exp_q.size(), 0);
   endtask

   task automatic directed(input string tag, input logic [31:0] ia, input logic [31:0] ib,
                           input logic ibin, input logic isat, input logic [31:0] ed,
                           input logic eb, input logic eo, input logic ez);
      int lat;
      drain();
      cycle(1'b1, ia, ib, ibin, isat, 1'b1);
      check_val({tag, "_accept"}, s_acc, 1);
      lat = 0;
      do begin
         cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
         lat++;
      end while (!s_ov && lat < 10);
      check_val({tag, "_latency"}, lat, 4);
      check_val({tag, "_diff"}, s_diff, ed);
      check_val({tag, "_bout"}, s_bout, eb);
      check_val({tag, "_ovf"}, s_ovf, eo);
      check_val({tag, "_zero"}, s_zero, ez);
   endtask

   initial begin
      #1_500_000;
      $display("FAIL timeout: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int acc;
      int cyc;
      int r0;
      int ov_seen;
      logic iv;
      logic ordy;

      rst       = 1'b1;
      in_valid  = 1'b0;
      a         = '0;
      b         = '0;
      bin       = 1'b0;
      sat       = 1'b0;
      out_ready = 1'b0;
      #2;
      check_val("rst_out_valid", out_valid, 0);
      check_val("rst_diff", diff, 0);
      check_val("rst_zero", zero, 0);
      check_val("rst_in_ready", in_ready, 1);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      directed("sub_5_3", 32'h5, 32'h3, 1'b0, 1'b0, 32'h2, 1'b0, 1'b0, 1'b0);
      directed("wrap_0_1", 32'h0, 32'h1, 1'b0, 1'b0, 32'hFFFF_FFFF, 1'b1, 1'b0, 1'b0);
      directed("clamp_0_1", 32'h0, 32'h1, 1'b0, 1'b1, 32'h0, 1'b1, 1'b0, 1'b1);
      directed("ovf_min", 32'h8000_0000, 32'h1, 1'b0, 1'b0, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0);
      directed("chunk_borrow", 32'h100, 32'h1, 1'b0, 1'b0, 32'hFF, 1'b0, 1'b0, 1'b0);
      directed("bin_in", 32'h5, 32'h3, 1'b1, 1'b0, 32'h1, 1'b0, 1'b0, 1'b0);
      directed("equal_zero", 32'hDEAD_BEEF, 32'hDEAD_BEEF, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

      // Back-to-back transfers with out_ready pattern 1,0,0 repeating.
      drain();
      r0  = n_retired;
      acc = 0;
      cyc = 0;
      while (acc < 8 && cyc < 100) begin
         cycle(1'b1, rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               (cyc % 3) == 0);
         if (s_acc) acc++;
         cyc++;
      end
      while (exp_q.size() > 0 && cyc < 200) begin
         cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, (cyc % 3) == 0);
         cyc++;
      end
      check_val("b2b_accepted", acc, 8);
      check_val("b2b_retired", n_retired - r0, 8);

      // Asynchronous reset with a full stalled pipe.
      drain();
      for (int i = 0; i < 4; i++) cycle(1'b1, rand_op(), rand_op(), 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0);
      check_val("rst_pre_out_valid", s_ov, 1);
      #2;
      rst = 1'b1;
      #1;
      check_val("async_rst_out_valid", out_valid, 0);
      check_val("async_rst_diff", diff, 0);
      check_val("async_rst_bout", bout, 0);
      check_val("async_rst_ovf", ovf, 0);
      check_val("async_rst_zero", zero, 0);
      check_val("async_rst_in_ready", in_ready, 1);
      exp_q.delete();
      @(negedge clk);
      rst = 1'b0;
      ov_seen = 0;
      for (int i = 0; i < 6; i++) begin
         cycle(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b1);
         if (s_ov) ov_seen++;
      end
      check_val("post_rst_quiet", ov_seen, 0);

      // Randomized regression.
      acc = 0;
      cyc = 0;
      while (acc < 10000 && cyc < 60000) begin
         iv   = ($urandom_range(0, 3) != 0);
         ordy = ($urandom_range(0, 3) != 0);
         cycle(iv, rand_op(), rand_op(), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               ordy);
         if (s_acc) acc++;
         cyc++;
      end
      check_val("rand_accepted", acc, 10000);
      drain();

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
